// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: fetches entries from a synchronous RAM and issues
// paced jump/draw commands to the vector control block at a fixed frame rate.
module vector_list_sequencer #(
    parameter int AW            = 10,
    parameter int FRAME_CYCLES  = 833333,
    parameter int SETTLE_CYCLES = 64,
    parameter int GUARD_CYCLES  = 2,
    parameter int FW            = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [25:0]   mem_rdata,
    output logic [11:0]   x,
    output logic [11:0]   y,
    output logic          jump,
    output logic          draw,
    input  logic          ready,
    output logic          busy,
    output logic          frame_start,
    output logic          overrun,
    output logic [15:0]   frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT_RDY,
        S_ISSUE,
        S_GUARD,
        S_SETTLE,
        S_FRAME_WAIT
    } state_t;

    localparam logic [1:0] OP_JUMP = 2'b00;
    localparam logic [1:0] OP_DRAW = 2'b01;
    localparam logic [1:0] OP_END  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam int DWELL_MAX = (SETTLE_CYCLES > GUARD_CYCLES) ? SETTLE_CYCLES : GUARD_CYCLES;
    localparam int DW        = $clog2(DWELL_MAX + 1);

    localparam logic [AW-1:0] LAST_ADDR  = '1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [DW-1:0] GUARD_LAST = DW'(GUARD_CYCLES - 1);
    localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE_CYCLES - 1);

    state_t        state;
    logic          cmd_jump;
    logic [DW-1:0] dwell;
    logic [FW-1:0] timer;

    logic [1:0] entry_op;
    logic       frame_due;
    logic       frame_go;
    logic       frame_stop;
    logic       guard_done;
    logic       settle_done;
    logic       cmd_done;
    logic       in_list;

    assign entry_op    = mem_rdata[25:24];
    assign frame_due   = (timer == FRAME_LAST);
    assign guard_done  = (dwell == GUARD_LAST);
    assign settle_done = (dwell == SETTLE_LAST);
    assign in_list     = (state != S_IDLE) && (state != S_FRAME_WAIT);

    // A new frame begins from IDLE on enable, or once the frame period has elapsed.
    assign frame_go   = enable && ((state == S_IDLE) || ((state == S_FRAME_WAIT) && frame_due));
    assign frame_stop = !enable && (state == S_FRAME_WAIT) && frame_due;

    // Command boundary: a NOP decode, a DRAW after guard, or a JUMP after settle.
    assign cmd_done = ((state == S_DECODE) && (entry_op == OP_NOP))
                   || ((state == S_GUARD) && guard_done && !cmd_jump)
                   || ((state == S_SETTLE) && settle_done);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cmd_jump    <= 1'b0;
            dwell       <= '0;
            timer       <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            x           <= '0;
            y           <= '0;
            jump        <= 1'b0;
            draw        <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in
            // this block, so every pulse output lasts exactly one cycle without extra logic.
            jump        <= 1'b0;
            draw        <= 1'b0;
            mem_rd      <= 1'b0;
            frame_start <= 1'b0;

            if ((state != S_IDLE) && !frame_due)
                timer <= timer + 1'b1;
            if (in_list && frame_due)
                overrun <= 1'b1;

            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (entry_op)
                        OP_END: state <= S_FRAME_WAIT;
                        OP_JUMP, OP_DRAW: begin
                            x        <= mem_rdata[23:12];
                            y        <= mem_rdata[11:0];
                            cmd_jump <= (entry_op == OP_JUMP);
                            state    <= S_WAIT_RDY;
                        end
                        default: ;
                    endcase
                end
                S_WAIT_RDY: begin
                    if (ready) begin
                        jump  <= cmd_jump;
                        draw  <= !cmd_jump;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dwell <= '0;
                    state <= S_GUARD;
                end
                S_GUARD: begin
                    // Ready is deliberately not looked at while guarding.
                    if (!guard_done) begin
                        dwell <= dwell + 1'b1;
                    end else if (cmd_jump) begin
                        dwell <= '0;
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!settle_done)
                        dwell <= dwell + 1'b1;
                end
                default: ;
            endcase

            if (cmd_done) begin
                if (!enable) begin
                    state <= S_IDLE;
                end else if (mem_addr == LAST_ADDR) begin
                    // The last list slot carries an implicit END; never wrap mid-frame.
                    state <= S_FRAME_WAIT;
                end else begin
                    mem_addr <= mem_addr + 1'b1;
                    mem_rd   <= 1'b1;
                    state    <= S_FETCH;
                end
            end

            if (frame_stop)
                state <= S_IDLE;

            if (frame_go) begin
                if (state == S_IDLE)
                    overrun <= 1'b0;
                timer       <= '0;
                mem_addr    <= '0;
                mem_rd      <= 1'b1;
                frame_start <= 1'b1;
                frame_count <= frame_count + 1'b1;
                state       <= S_FETCH;
            end
        end
    end

    a_pulse_exclusive : assert property (@(posedge clk) disable iff (!reset_n) !(jump && draw));
    a_read_in_fetch   : assert property (@(posedge clk) disable iff (!reset_n) mem_rd == (state == S_FETCH));
    a_pulse_in_issue  : assert property (@(posedge clk) disable iff (!reset_n) (jump || draw) == (state == S_ISSUE));

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench for vector_list_sequencer: directed display lists, expected
// commands queued by the stimulus and checked by an independent monitor.
module tb_vector_list_sequencer;

    localparam int AW     = 4;
    localparam int FC     = 200;
    localparam int SETTLE = 16;
    localparam int GUARD  = 2;
    localparam int FW     = 20;

    localparam int K_JUMP = 0;
    localparam int K_DRAW = 1;
    localparam int K_FS   = 2;
    localparam int K_IDLE = 3;

    typedef struct packed {
        logic        is_jump;
        logic [11:0] x;
        logic [11:0] y;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [25:0]   mem_rdata;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          jump;
    logic          draw;
    logic          ready;
    logic          busy;
    logic          frame_start;
    logic          overrun;
    logic [15:0]   frame_count;

    logic [25:0] mem [2**AW];
    cmd_t        exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int jump_cnt = 0, draw_cnt = 0, fs_cnt = 0, idle_cnt = 0, rd_cnt = 0;
    int jump_cyc = 0, draw_cyc = 0, fs_cyc = 0, fs_prev_cyc = 0, idle_cyc = 0;
    int mark     = 0;
    logic prev_busy = 1'b0;

    vector_list_sequencer #(
        .AW(AW), .FRAME_CYCLES(FC), .SETTLE_CYCLES(SETTLE), .GUARD_CYCLES(GUARD), .FW(FW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .x(x), .y(y), .jump(jump), .draw(draw), .ready(ready), .busy(busy),
        .frame_start(frame_start), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous display-list RAM: data appears the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    function automatic logic [25:0] ent(input logic [1:0] op, input int ex, input int ey);
        return {op, 12'(ex), 12'(ey)};
    endfunction

    function automatic cmd_t cmd(input logic j, input int ex, input int ey);
        return '{is_jump: j, x: 12'(ex), y: 12'(ey)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input string what, input int kind, input int target, input int budget);
        int  n;
        bit  hit;
        n = 0;
        forever begin
            step(1);
            case (kind)
                K_JUMP:  hit = (jump_cnt >= target);
                K_DRAW:  hit = (draw_cnt >= target);
                K_FS:    hit = (fs_cnt   >= target);
                default: hit = (idle_cnt >= target);
            endcase
            if (hit) break;
            n++;
            if (n >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout %s: no event after %0d cycles", what, budget);
                break;
            end
        end
    endtask

    task automatic load_jdraw_list();
        for (int i = 0; i < 2**AW; i++) mem[i] = ent(2'b10, 0, 0);
        mem[0] = ent(2'b00, 100, 200);
        mem[1] = ent(2'b01, 300, 400);
        mem[2] = ent(2'b10, 0, 0);
    endtask

    // Monitor: pops the scoreboard on every command pulse, checks frame starts.
    always @(negedge clk) begin
        cmd_t e;
        if (mem_rd) rd_cnt++;
        if (jump || draw) begin
            check("pulse_exclusive", {jump, draw} == 2'b11, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got jump=%0b draw=%0b x=%0d y=%0d, expected none",
                         jump, draw, x, y);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", jump, e.is_jump);
                check("pulse_x", x, e.x);
                check("pulse_y", y, e.y);
            end
            if (jump) begin jump_cnt++; jump_cyc = cyc; end
            else      begin draw_cnt++; draw_cyc = cyc; end
        end
        if (frame_start) begin
            fs_cnt++;
            fs_prev_cyc = fs_cyc;
            fs_cyc      = cyc;
            check("frame_addr0", mem_addr, 0);
            check("frame_rd", mem_rd, 1);
            check("frame_count", frame_count, fs_cnt);
        end
        if (prev_busy && !busy) begin
            idle_cnt++;
            idle_cyc = cyc;
        end
        prev_busy = busy;
    end

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        ready   = 1'b1;
        load_jdraw_list();
        #1 reset_n = 1'b0;
        #2;
        check("reset_outputs",
              {mem_addr, mem_rd, x, y, jump, draw, busy, frame_start, overrun, frame_count}, 0);
        step(3);
        reset_n = 1'b1;
        step(1);
        check("idle_busy", busy, 0);

        // Frame 1 runs fully, frame 2 stopped during the jump's settle.
        exp_q.push_back(cmd(1'b1, 100, 200));
        exp_q.push_back(cmd(1'b0, 300, 400));
        exp_q.push_back(cmd(1'b1, 100, 200));
        enable = 1'b1;
        wait_for("draw1", K_DRAW, 1, 100);
        check("jump_to_draw", draw_cyc - jump_cyc, SETTLE + GUARD + 4);
        wait_for("frame2", K_FS, 2, 2 * FC);
        check("frame_period", fs_cyc - fs_prev_cyc, FC);
        check("frame_count_2", frame_count, 2);
        wait_for("jump2", K_JUMP, 2, 50);
        step(5);
        enable = 1'b0;
        mark   = rd_cnt;
        wait_for("idle1", K_IDLE, 1, 100);
        check("settle_to_idle", idle_cyc - jump_cyc, GUARD + SETTLE + 1);
        check("no_fetch_after_drop", rd_cnt, mark);
        check("queue_empty_1", exp_q.size(), 0);

        // Frame 3: draw held off by ready low in WAIT_RDY.
        exp_q.push_back(cmd(1'b1, 100, 200));
        exp_q.push_back(cmd(1'b0, 300, 400));
        enable = 1'b1;
        wait_for("frame3", K_FS, 3, 20);
        check("overrun_clear_f3", overrun, 0);
        wait_for("jump3", K_JUMP, 3, 50);
        ready = 1'b0;
        step(50);
        check("hold_x", x, 300);
        check("hold_y", y, 400);
        check("hold_no_draw", draw_cnt, 1);
        check("hold_busy", busy, 1);
        ready = 1'b1;
        mark  = cyc;
        wait_for("draw3", K_DRAW, 2, 20);
        check("draw_after_ready", draw_cyc, mark + 1);

        // Frame 4 overruns on a long stall; frame 5 starts right after END.
        exp_q.push_back(cmd(1'b1, 100, 200));
        exp_q.push_back(cmd(1'b0, 300, 400));
        exp_q.push_back(cmd(1'b1, 100, 200));
        ready = 1'b0;
        wait_for("frame4", K_FS, 4, 2 * FC);
        step(FC + 50);
        check("overrun_set", overrun, 1);
        check("stall_x", x, 100);
        check("stall_no_jump", jump_cnt, 3);
        ready = 1'b1;
        wait_for("draw4", K_DRAW, 3, 100);
        wait_for("frame5", K_FS, 5, 20);
        check("overrun_restart", fs_cyc - draw_cyc, GUARD + 4);
        check("overrun_sticky", overrun, 1);
        wait_for("jump5", K_JUMP, 5, 20);
        enable = 1'b0;
        wait_for("idle2", K_IDLE, 2, 100);
        check("overrun_held_idle", overrun, 1);

        // Frames 6 and 7: NOP list with a DRAW only in the last slot.
        for (int i = 0; i < 2**AW; i++) mem[i] = ent(2'b11, 0, 0);
        mem[2**AW-1] = ent(2'b01, 7, 7);
        exp_q.push_back(cmd(1'b0, 7, 7));
        exp_q.push_back(cmd(1'b0, 7, 7));
        enable = 1'b1;
        wait_for("frame6", K_FS, 6, 20);
        check("overrun_cleared", overrun, 0);
        wait_for("draw6", K_DRAW, 4, 100);
        check("draw_last_addr", mem_addr, 2**AW - 1);
        wait_for("frame7", K_FS, 7, 2 * FC);
        check("wrap_period", fs_cyc - fs_prev_cyc, FC);
        wait_for("draw7", K_DRAW, 5, 100);
        enable = 1'b0;
        wait_for("idle3", K_IDLE, 3, 20);
        check("queue_empty_2", exp_q.size(), 0);

        // Frame 8: reset while waiting for ready.
        load_jdraw_list();
        ready  = 1'b0;
        enable = 1'b1;
        wait_for("frame8", K_FS, 8, 20);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset",
              {mem_addr, mem_rd, x, y, jump, draw, busy, frame_start, overrun, frame_count}, 0);
        fs_cnt = 0;
        ready  = 1'b1;
        step(4);
        check("no_pulse_in_reset", jump_cnt, 5);
        check("reset_frame_count", frame_count, 0);
        enable  = 1'b0;
        reset_n = 1'b1;
        step(4);
        check("post_reset_idle", busy, 0);
        check("queue_empty_3", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/vector_list_sequencer.md
Name: vector_list_sequencer

Overview:
- Walks a display list in an external synchronous RAM and feeds the vector control block one command at a time.
- Each command is issued as a one-cycle jump or draw pulse with registered x/y, paced by the control block's ready.
- Handles the beam-settle delay after jumps.
- Enforces a fixed frame refresh period, re-running the list from address 0 every frame while enabled.

Parameters:
AW, 10, display-list address width (list depth 2^AW)
FRAME_CYCLES, 833333, minimum clk cycles from frame start to next frame start (60 Hz at 50 MHz)
SETTLE_CYCLES, 64, idle cycles inserted after every jump before the next command is issued
GUARD_CYCLES, 2, cycles after an issue pulse during which ready is ignored
FW, 20, width of frame timer (must hold FRAME_CYCLES)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run frames, 0 = stop at next command boundary
mem_addr  out  AW  display-list read address
mem_rd  out  1  read strobe; data valid on mem_rdata the following cycle
mem_rdata  in  26  entry: [25:24] op (00 JUMP, 01 DRAW, 10 END, 11 NOP), [23:12] x, [11:0] y
x  out  12  target x to control block
y  out  12  target y to control block
jump  out  1  one-cycle jump pulse
draw  out  1  one-cycle draw pulse
ready  in  1  control block ready
busy  out  1  high in any state except IDLE
frame_start  out  1  one-cycle pulse when a frame's first fetch is issued
overrun  out  1  sticky: list took longer than FRAME_CYCLES; cleared on IDLE->run
frame_count  out  16  frames started since reset, wraps at 65535->0

Behaviour:
- Reset is asynchronous, active-low. On assertion, all outputs go to 0, state goes to IDLE, and all counters clear.
- States: IDLE, FETCH, DECODE, WAIT_RDY, ISSUE, GUARD, SETTLE, FRAME_WAIT.
- IDLE:
  - When enable=1, go to FETCH with mem_addr=0 and frame timer=0.
  - Pulse frame_start, increment frame_count, clear overrun.
- FETCH: mem_rd=1 for exactly one cycle, then go to DECODE.
- DECODE: capture mem_rdata (the cycle after mem_rd).
  - NOP: addr+1, then FETCH.
  - END: go to FRAME_WAIT.
  - JUMP/DRAW: latch op/x/y, then WAIT_RDY.
- WAIT_RDY:
  - Hold until ready=1, then ISSUE.
  - x/y are registered and stable from WAIT_RDY entry through the end of GUARD.
- ISSUE:
  - Exactly one cycle of jump=1 or draw=1 (never both).
  - Then GUARD, which lasts GUARD_CYCLES cycles regardless of ready; this masks ready staying high for a cycle or two after the pulse.
  - After GUARD: a JUMP goes to SETTLE for SETTLE_CYCLES; a DRAW goes straight on.
  - Then addr+1 and FETCH; if enable=0 at that boundary, go to IDLE instead.
- Address wrap: if an executed entry sits at address 2^AW-1, treat it as followed by an implicit END. The address never wraps mid-frame.
- FRAME_WAIT:
  - Wait until the frame timer reaches FRAME_CYCLES-1.
  - If enable=1: timer=0, addr=0, pulse frame_start, increment frame_count, go to FETCH.
  - Otherwise go to IDLE.
- Frame timer:
  - Increments every cycle while busy and saturates at FRAME_CYCLES-1.
  - If it saturates before END is decoded, set overrun=1. The list keeps running and FRAME_WAIT exits immediately.
- enable deasserted mid-command: the current command still completes (issue, guard and settle) before IDLE. A command in WAIT_RDY is still issued.
- Throughput: a DRAW takes at least 4+GUARD_CYCLES cycles per entry (FETCH, DECODE, WAIT_RDY with ready=1, ISSUE, GUARD).
- Reset mid-operation aborts immediately. No pulse may appear on jump/draw in the cycle of or after reset assertion.

Test Plan:
- List {JUMP(100,200), DRAW(300,400), END}, ready tied 1, enable=1 -> jump pulse with x=100,y=200; draw follows exactly SETTLE_CYCLES+GUARD_CYCLES+4 cycles later with x=300,y=400; frame_start spacing = FRAME_CYCLES; frame_count increments.
- Same list, ready held 0 for 50 cycles after the jump, then 1 -> draw held off until ready=1; x/y stable; jump not re-pulsed; ready high during GUARD ignored.
- FRAME_CYCLES=40 with 10 DRAW entries -> overrun=1 after the first frame; next frame starts immediately after END; overrun clears only after enable is toggled 0->1.
- List with no END and all NOPs except address 2^AW-1 = DRAW(7,7) -> draw issued at last address; next fetch is address 0 of a new frame.
- enable dropped during SETTLE -> SETTLE completes, no further mem_rd, busy=0; re-enable -> fetch starts at address 0.
- reset_n pulsed low during WAIT_RDY -> outputs 0 asynchronously; no jump/draw pulse; frame_count=0.
